// File: rtl/mux_arb_pkg.sv
// ============================================================================
// mux_arb_pkg : shared types and constants for the round-robin mux arbiter
// Revision    : 1.0
// ============================================================================
`default_nettype none

package mux_arb_pkg;

    localparam int DATA_W = 32;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mux_arbiter_mux.sv
// ============================================================================
// Mux : 2:1 datapath multiplexer (sel=0 -> a, sel=1 -> b)
// Revision : 1.0
// ============================================================================
`default_nettype none

module Mux #(
    parameter int WIDTH = 32
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    assign y = sel ? b : a;

endmodule

`default_nettype wire

// File: rtl/mux_arbiter.sv
// ============================================================================
// mux_arbiter : round-robin arbiter sharing one 2:1 mux, registered output
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mux_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             y_valid,
    output logic [WIDTH-1:0] y_data,
    input  logic             y_ready,
    output logic             y_src
);

    state_t           state_q;
    state_t           state_d;
    logic             last_q;
    logic [WIDTH-1:0] y_data_q;
    logic             y_src_q;
    logic             grant;
    logic             load;
    logic             xfer;
    logic [WIDTH-1:0] mux_y;

    // Ties go to the side that did not win the previous transfer.
    always_comb begin
        grant = SRC_A;
        if (a_valid && b_valid) begin
            grant = ~last_q;
        end else if (b_valid) begin
            grant = SRC_B;
        end
    end

    // Readies are gated by rst_n so no handshake completes while in reset.
    assign load    = (state_q == ST_EMPTY) || y_ready;
    assign a_ready = rst_n && load && (grant == SRC_A) && a_valid;
    assign b_ready = rst_n && load && (grant == SRC_B) && b_valid;
    assign xfer    = a_ready || b_ready;

    Mux #(
        .WIDTH (WIDTH)
    ) u_mux (
        .sel (grant),
        .a   (a_data),
        .b   (b_data),
        .y   (mux_y)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (xfer) state_d = ST_FULL;
            ST_FULL: begin
                if (xfer)         state_d = ST_FULL;
                else if (y_ready) state_d = ST_EMPTY;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            last_q   <= SRC_B;
            y_data_q <= '0;
            y_src_q  <= SRC_A;
        end else begin
            state_q <= state_d;
            if (xfer) begin
                y_data_q <= mux_y;
                y_src_q  <= grant;
                last_q   <= grant;
            end
        end
    end

    assign y_valid = (state_q == ST_FULL);
    assign y_data  = y_data_q;
    assign y_src   = y_src_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_arbiter.sv
// ============================================================================
// tb_mux_arbiter : scenario-driven scoreboard bench for mux_arbiter
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_mux_arbiter;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             a_valid = 1'b0;
    logic [WIDTH-1:0] a_data = '0;
    logic             a_ready;
    logic             b_valid = 1'b0;
    logic [WIDTH-1:0] b_data = '0;
    logic             b_ready;
    logic             y_valid;
    logic [WIDTH-1:0] y_data;
    logic             y_ready = 1'b0;
    logic             y_src;

    int n_checks = 0;
    int n_pass   = 0;

    // Scoreboard entries are {src, data}.
    logic [WIDTH:0] exp_q[$];
    logic [WIDTH:0] exp_item;
    logic           m_last;

    always #5 clk = ~clk;

    mux_arbiter #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_valid (a_valid),
        .a_data  (a_data),
        .a_ready (a_ready),
        .b_valid (b_valid),
        .b_data  (b_data),
        .b_ready (b_ready),
        .y_valid (y_valid),
        .y_data  (y_data),
        .y_ready (y_ready),
        .y_src   (y_src)
    );

    task automatic test_reset;
        @(negedge clk);
        rst_n = 1'b0; a_valid = 1'b1; b_valid = 1'b1; y_ready = 1'b0;
        a_data = 32'h1111_1111; b_data = 32'h2222_2222;
        #1;
        n_checks++; if (y_valid !== 1'b0) $display("FAIL reset_y_valid got=%b exp=0", y_valid); else n_pass++;
        n_checks++; if (y_data !== '0) $display("FAIL reset_y_data got=%h exp=0", y_data); else n_pass++;
        n_checks++; if ({a_ready, b_ready} !== 2'b00) $display("FAIL reset_readies got=%b exp=00", {a_ready, b_ready}); else n_pass++;
        @(negedge clk);
        n_checks++; if (y_valid !== 1'b0) $display("FAIL reset_hold_y_valid got=%b exp=0", y_valid); else n_pass++;
        rst_n = 1'b1;
        #1;
        n_checks++; if ({a_ready, b_ready} !== 2'b10) $display("FAIL reset_first_grant got=%b exp=10", {a_ready, b_ready}); else n_pass++;
        a_valid = 1'b0; b_valid = 1'b0;
        m_last = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_single_a;
        @(negedge clk);
        a_valid = 1'b1; a_data = 32'hAAAA_AAAA; b_valid = 1'b0; y_ready = 1'b1;
        #1;
        n_checks++; if ({a_ready, b_ready} !== 2'b10) $display("FAIL single_a_ready got=%b exp=10", {a_ready, b_ready}); else n_pass++;
        exp_q.push_back({1'b0, 32'hAAAA_AAAA}); m_last = 1'b0;
        @(negedge clk);
        a_valid = 1'b0;
        exp_item = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        n_checks++;
        if (y_valid !== 1'b1 || {y_src, y_data} !== exp_item)
            $display("FAIL single_a_out got=%b/%b/%h exp=1/%b/%h", y_valid, y_src, y_data, exp_item[WIDTH], exp_item[WIDTH-1:0]);
        else n_pass++;
    endtask

    task automatic test_tie_alternation;
        logic g;
        @(negedge clk);
        rst_n = 1'b0; #2; rst_n = 1'b1; m_last = 1'b1; exp_q.delete();
        a_valid = 1'b1; a_data = 32'hAAAA_AAAA;
        b_valid = 1'b1; b_data = 32'h5555_5555; y_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            g = ~m_last;
            n_checks++;
            if ({a_ready, b_ready} !== {~g, g})
                $display("FAIL tie_ready[%0d] got=%b exp=%b", i, {a_ready, b_ready}, {~g, g});
            else n_pass++;
            exp_q.push_back({g, g ? b_data : a_data}); m_last = g;
            @(negedge clk);
            exp_item = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            n_checks++;
            if (y_valid !== 1'b1 || {y_src, y_data} !== exp_item)
                $display("FAIL tie_out[%0d] got=%b/%b/%h exp=1/%b/%h", i, y_valid, y_src, y_data, exp_item[WIDTH], exp_item[WIDTH-1:0]);
            else n_pass++;
        end
        a_valid = 1'b0; b_valid = 1'b0;
    endtask

    task automatic test_backpressure;
        a_valid = 1'b1; a_data = 32'hAAAA_AAAA; y_ready = 1'b1;
        #1;
        n_checks++; if (a_ready !== 1'b1) $display("FAIL bp_load_a got=%b exp=1", a_ready); else n_pass++;
        exp_q.push_back({1'b0, 32'hAAAA_AAAA}); m_last = 1'b0;
        @(negedge clk);
        exp_item = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        n_checks++;
        if ({y_src, y_data} !== exp_item) $display("FAIL bp_first got=%b/%h exp=%b/%h", y_src, y_data, exp_item[WIDTH], exp_item[WIDTH-1:0]);
        else n_pass++;
        a_valid = 1'b0; b_valid = 1'b1; b_data = 32'hFFFF_FFFF; y_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (b_ready !== 1'b0) $display("FAIL bp_b_ready[%0d] got=%b exp=0", i, b_ready); else n_pass++;
            @(negedge clk);
            n_checks++;
            if (y_valid !== 1'b1 || y_data !== 32'hAAAA_AAAA)
                $display("FAIL bp_hold[%0d] got=%b/%h exp=1/aaaaaaaa", i, y_valid, y_data);
            else n_pass++;
        end
        y_ready = 1'b1;
        #1;
        n_checks++; if (b_ready !== 1'b1) $display("FAIL bp_release_b_ready got=%b exp=1", b_ready); else n_pass++;
        exp_q.push_back({1'b1, 32'hFFFF_FFFF}); m_last = 1'b1;
        @(negedge clk);
        b_valid = 1'b0;
        exp_item = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        n_checks++;
        if (y_valid !== 1'b1 || {y_src, y_data} !== exp_item)
            $display("FAIL bp_release_out got=%b/%b/%h exp=1/%b/%h", y_valid, y_src, y_data, exp_item[WIDTH], exp_item[WIDTH-1:0]);
        else n_pass++;
    endtask

    task automatic test_drain;
        a_valid = 1'b0; b_valid = 1'b0; y_ready = 1'b1;
        #1;
        n_checks++; if ({a_ready, b_ready} !== 2'b00) $display("FAIL drain_readies got=%b exp=00", {a_ready, b_ready}); else n_pass++;
        @(negedge clk);
        n_checks++;
        if (y_valid !== 1'b0 || y_data !== 32'hFFFF_FFFF)
            $display("FAIL drain_out got=%b/%h exp=0/ffffffff", y_valid, y_data);
        else n_pass++;
        n_checks++; if (exp_q.size() != 0) $display("FAIL drain_scoreboard got=%0d exp=0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_reset_mid_stream;
        a_valid = 1'b1; a_data = 32'hA5A5_A5A5; y_ready = 1'b1;
        #1;
        exp_q.push_back({1'b0, 32'hA5A5_A5A5});
        @(negedge clk);
        y_ready = 1'b0;
        exp_item = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        n_checks++;
        if (y_valid !== 1'b1 || {y_src, y_data} !== exp_item)
            $display("FAIL mid_full got=%b/%b/%h exp=1/%b/%h", y_valid, y_src, y_data, exp_item[WIDTH], exp_item[WIDTH-1:0]);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (y_valid !== 1'b0 || y_data !== '0 || y_src !== 1'b0)
            $display("FAIL mid_reset_out got=%b/%b/%h exp=0/0/00000000", y_valid, y_src, y_data);
        else n_pass++;
        y_ready = 1'b1;
        #1;
        n_checks++; if ({a_ready, b_ready} !== 2'b00) $display("FAIL mid_reset_readies got=%b exp=00", {a_ready, b_ready}); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1; a_valid = 1'b0; y_ready = 1'b0;
        m_last = 1'b1;
    endtask

    initial begin
        m_last = 1'b1;
        test_reset();
        test_single_a();
        test_tie_alternation();
        test_backpressure();
        test_drain();
        test_reset_mid_stream();
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
